// File: rtl/if_pkg.sv
// ----------------------------------------------------------------------------
// if_pkg
//   Shared constants and types for the instruction-fetch prefetch stage.
//   IF_NOP       : value loaded into the IF/ID instruction on a bubble
//   IF_RESET_PC  : default PC after reset
//   if_qentry_t  : one prefetch queue entry {pc_next, instr} at the default
//                  datapath width (the FIFO itself is width-generic)
// ----------------------------------------------------------------------------
package if_pkg;
   localparam int          IF_XLEN     = 32;
   localparam logic [31:0] IF_NOP      = 32'h0;
   localparam logic [31:0] IF_RESET_PC = 32'h0;

   typedef struct packed {
      logic [IF_XLEN-1:0] pc_next;
      logic [31:0]        instr;
   } if_qentry_t;
endpackage

// File: rtl/if_prefetch_fifo.sv
// ----------------------------------------------------------------------------
// if_prefetch_fifo
//   DEPTH-entry synchronous FIFO with clear. Head is read combinationally.
//   The caller must not pop when empty, nor push when full without a pop.
//   Ports:
//     clk, rst_n   clock, async active-low reset
//     clr          empty the FIFO (wins over push/pop)
//     push, din    write din at the tail
//     pop          advance the head
//     dout         current head entry
//     count        number of valid entries, 0..DEPTH
// ----------------------------------------------------------------------------
module if_prefetch_fifo #(
   parameter int DW    = 64,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic                       push,
   input  logic                       pop,
   input  logic [DW-1:0]              din,
   output logic [DW-1:0]              dout,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
         // push+pop together leaves count unchanged
         count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;
endmodule

// File: rtl/if_prefetch_stage.sv
// ----------------------------------------------------------------------------
// if_prefetch_stage
//   Instruction-fetch stage with a prefetch queue between PC/IMEM and IF/ID.
//   Fetch keeps filling the queue while ID stalls; redirects clear the queue.
//   A debug freeze (stall_breakpoint & ~continue_en) holds everything and
//   drops any redirect presented during it.
//   Ports:
//     clk, rst_n                 clock, async active-low reset
//     jump_taken/pc_jump         redirect (beats branch)
//     branch_taken/pc_branch     redirect
//     flush_if                   bubble IF/ID this edge
//     stall                      hold IF/ID, no pop
//     stall_breakpoint,
//     continue_en                freeze request / override
//     imem_addr, imem_rdata      async-read IMEM interface (word address)
//     if_id_valid/instruction/
//     if_id_pc_next              IF/ID register to the decode stage
//   Optional (macro IF_PERF_CNT_EN): perf_fetch_cnt, perf_bubble_cnt,
//     perf_redirect_cnt, 32-bit wrapping event counters held during freeze.
// ----------------------------------------------------------------------------
module if_prefetch_stage
   import if_pkg::*;
#(
   parameter int               XLEN     = IF_XLEN,
   parameter int               IMEM_AW  = 8,
   parameter int               QDEPTH   = 4,
   parameter logic [XLEN-1:0]  RESET_PC = XLEN'(IF_RESET_PC)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                jump_taken,
   input  logic                branch_taken,
   input  logic [XLEN-1:0]     pc_jump,
   input  logic [XLEN-1:0]     pc_branch,
   input  logic                flush_if,
   input  logic                stall,
   input  logic                stall_breakpoint,
   input  logic                continue_en,
   output logic [IMEM_AW-1:0]  imem_addr,
   input  logic [31:0]         imem_rdata,
   output logic                if_id_valid,
   output logic [31:0]         if_id_instruction,
   output logic [XLEN-1:0]     if_id_pc_next
`ifdef IF_PERF_CNT_EN
  ,output logic [31:0]         perf_fetch_cnt,
   output logic [31:0]         perf_bubble_cnt,
   output logic [31:0]         perf_redirect_cnt
`endif
);
   localparam int CW = $clog2(QDEPTH) + 1;
   localparam int DW = XLEN + 32;

   logic [XLEN-1:0] pc_q, pc_d, pc_plus4;
   logic            ifv_q, ifv_d;
   logic [31:0]     ifi_q, ifi_d;
   logic [XLEN-1:0] ifp_q, ifp_d;

   logic            freeze, redirect, pop, push_ok, q_clr, load_bubble;
   logic [CW-1:0]   q_count;
   logic [DW-1:0]   q_head;

   assign freeze   = stall_breakpoint & ~continue_en;
   assign redirect = jump_taken | branch_taken;
   assign pc_plus4 = pc_q + XLEN'(4);

   assign pop     = ~freeze & ~stall & ~flush_if & ~redirect & (q_count != '0);
   // A full queue still accepts a push when the head leaves on the same edge
   assign push_ok = ~freeze & ~redirect &
                    ((q_count < CW'(QDEPTH)) | pop);
   assign q_clr   = ~freeze & redirect;

   if_prefetch_fifo #(.DW(DW), .DEPTH(QDEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (q_clr),
      .push  (push_ok),
      .pop   (pop),
      .din   ({pc_plus4, imem_rdata}),
      .dout  (q_head),
      .count (q_count)
   );

   always_comb begin
      pc_d = pc_q;
      if (!freeze) begin
         if (jump_taken)        pc_d = pc_jump;
         else if (branch_taken) pc_d = pc_branch;
         else if (push_ok)      pc_d = pc_plus4;
      end
   end

   always_comb begin
      ifv_d       = ifv_q;
      ifi_d       = ifi_q;
      ifp_d       = ifp_q;
      load_bubble = 1'b0;
      if (!freeze) begin
         if (flush_if || redirect) begin
            ifv_d = 1'b0; ifi_d = IF_NOP; ifp_d = '0; load_bubble = 1'b1;
         end else if (!stall) begin
            if (pop) begin
               ifv_d = 1'b1;
               ifi_d = q_head[31:0];
               ifp_d = q_head[DW-1:32];
            end else begin
               ifv_d = 1'b0; ifi_d = IF_NOP; ifp_d = '0; load_bubble = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q  <= RESET_PC;
         ifv_q <= 1'b0;
         ifi_q <= '0;
         ifp_q <= '0;
      end else begin
         pc_q  <= pc_d;
         ifv_q <= ifv_d;
         ifi_q <= ifi_d;
         ifp_q <= ifp_d;
      end
   end

   assign imem_addr         = pc_q[IMEM_AW+1:2];
   assign if_id_valid       = ifv_q;
   assign if_id_instruction = ifi_q;
   assign if_id_pc_next     = ifp_q;

`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] bubble_cnt_q, bubble_cnt_d;
   logic [31:0] redir_cnt_q, redir_cnt_d;

   // freeze already masks push_ok, load_bubble and q_clr
   always_comb begin
      fetch_cnt_d  = fetch_cnt_q  + 32'(push_ok);
      bubble_cnt_d = bubble_cnt_q + 32'(load_bubble);
      redir_cnt_d  = redir_cnt_q  + 32'(q_clr);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_q  <= '0;
         bubble_cnt_q <= '0;
         redir_cnt_q  <= '0;
      end else begin
         fetch_cnt_q  <= fetch_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
         redir_cnt_q  <= redir_cnt_d;
      end
   end

   assign perf_fetch_cnt    = fetch_cnt_q;
   assign perf_bubble_cnt   = bubble_cnt_q;
   assign perf_redirect_cnt = redir_cnt_q;
`endif
endmodule

// File: tb/tb_if_prefetch_stage.sv
module tb_if_prefetch_stage;
   import if_pkg::*;

   localparam int QD = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        jump_taken = 0, branch_taken = 0, flush_if = 0, stall = 0;
   logic        stall_breakpoint = 0, continue_en = 0;
   logic [31:0] pc_jump = '0, pc_branch = '0;
   logic [7:0]  imem_addr;
   logic [31:0] imem_rdata;
   logic        if_id_valid;
   logic [31:0] if_id_instruction;
   logic [31:0] if_id_pc_next;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt, perf_bubble_cnt, perf_redirect_cnt;
`endif

   logic [31:0] imem [256];
   assign imem_rdata = imem[imem_addr];

   always #5 clk = ~clk;

   if_prefetch_stage dut (
      .clk(clk), .rst_n(rst_n),
      .jump_taken(jump_taken), .branch_taken(branch_taken),
      .pc_jump(pc_jump), .pc_branch(pc_branch),
      .flush_if(flush_if), .stall(stall),
      .stall_breakpoint(stall_breakpoint), .continue_en(continue_en),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .if_id_valid(if_id_valid), .if_id_instruction(if_id_instruction),
      .if_id_pc_next(if_id_pc_next)
`ifdef IF_PERF_CNT_EN
     ,.perf_fetch_cnt(perf_fetch_cnt), .perf_bubble_cnt(perf_bubble_cnt),
      .perf_redirect_cnt(perf_redirect_cnt)
`endif
   );

   int n_chk = 0, n_pass = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Reference model: PC, a queue of {pc_next, instr}, the IF/ID contents
   logic [31:0] m_pc;
   if_qentry_t  m_q[$];
   logic        m_v;
   logic [31:0] m_instr, m_pcn;
   int unsigned m_fetch, m_bub, m_redir;

   task automatic model_reset();
      m_pc = IF_RESET_PC; m_q.delete();
      m_v = 0; m_instr = 0; m_pcn = 0;
      m_fetch = 0; m_bub = 0; m_redir = 0;
   endtask

   // Evaluate one clock edge from the spec rules, using the inputs held across it
   task automatic model_edge();
      bit fz, rd, pop, push;
      if_qentry_t h, e;
      fz = stall_breakpoint && !continue_en;
      rd = jump_taken || branch_taken;
      if (fz) return;
      pop = !stall && !flush_if && !rd && (m_q.size() != 0);
      h = '0;
      if (m_q.size() != 0) h = m_q[0];
      if (rd) begin
         m_pc = jump_taken ? pc_jump : pc_branch;
         m_q.delete();
         m_redir++;
      end else begin
         push = (m_q.size() < QD) || pop;
         if (pop) void'(m_q.pop_front());
         if (push) begin
            e.pc_next = m_pc + 32'd4;
            e.instr   = imem[m_pc[9:2]];
            m_q.push_back(e);
            m_pc = m_pc + 32'd4;
            m_fetch++;
         end
      end
      if (flush_if || rd) begin
         m_v = 0; m_instr = 0; m_pcn = 0; m_bub++;
      end else if (!stall) begin
         if (pop) begin
            m_v = 1; m_instr = h.instr; m_pcn = h.pc_next;
         end else begin
            m_v = 0; m_instr = 0; m_pcn = 0; m_bub++;
         end
      end
   endtask

   task automatic compare(input string ph);
      check({ph, ".valid"}, 64'(if_id_valid), 64'(m_v));
      check({ph, ".instr"}, 64'(if_id_instruction), 64'(m_instr));
      check({ph, ".pcn"},   64'(if_id_pc_next), 64'(m_pcn));
      check({ph, ".iaddr"}, 64'(imem_addr), 64'(m_pc[9:2]));
`ifdef IF_PERF_CNT_EN
      check({ph, ".pf_fetch"}, 64'(perf_fetch_cnt), 64'(m_fetch));
      check({ph, ".pf_bub"},   64'(perf_bubble_cnt), 64'(m_bub));
      check({ph, ".pf_redir"}, 64'(perf_redirect_cnt), 64'(m_redir));
`endif
   endtask

   task automatic drive(input logic j, input logic b, input logic [31:0] pj,
                        input logic [31:0] pb, input logic fl, input logic st,
                        input logic bp, input logic ce);
      jump_taken = j; branch_taken = b; pc_jump = pj; pc_branch = pb;
      flush_if = fl; stall = st; stall_breakpoint = bp; continue_en = ce;
   endtask

   task automatic cyc(input string ph);
      @(posedge clk);
      model_edge();
      #1 compare(ph);
   endtask

   task automatic idle(); drive(0, 0, 0, 0, 0, 0, 0, 0); endtask

   task automatic do_reset();
      rst_n = 0;
      model_reset();
      @(posedge clk); #1;
      rst_n = 1;
   endtask

   logic [7:0]  saved_addr;
   logic [31:0] saved_instr;
   int unsigned bub0;

   initial begin
      for (int k = 0; k < 256; k++) imem[k] = k + 1;
      model_reset();
      idle();

      // reset state
      #12;
      check("rst.valid", 64'(if_id_valid), 64'd0);
      check("rst.instr", 64'(if_id_instruction), 64'd0);
      check("rst.pcn",   64'(if_id_pc_next), 64'd0);
      check("rst.iaddr", 64'(imem_addr), 64'd0);
      @(posedge clk); #1 rst_n = 1;

      // 1: sequential fetch, two-edge latency
      cyc("t1e1");
      check("t1e1.v", 64'(if_id_valid), 64'd0);
      cyc("t1e2");
      check("t1e2.i", 64'(if_id_instruction), 64'd1);
      check("t1e2.p", 64'(if_id_pc_next), 64'd4);
      cyc("t1e3");
      check("t1e3.i", 64'(if_id_instruction), 64'd2);
      check("t1e3.p", 64'(if_id_pc_next), 64'd8);
      cyc("t1e4");
      check("t1e4.p", 64'(if_id_pc_next), 64'd12);
      cyc("t1e5"); cyc("t1e6");

      // 2: stall fills the queue, release drains it in order
      drive(0, 0, 0, 0, 0, 1, 0, 0);
      saved_instr = if_id_instruction;
      for (int i = 0; i < 5; i++) cyc("t2st");
      check("t2.hold", 64'(if_id_instruction), 64'(saved_instr));
      idle();
      for (int i = 0; i < 6; i++) begin
         cyc("t2rel");
         check("t2.seq", 64'(if_id_instruction), 64'(saved_instr + 32'(i) + 1));
      end

      // 3: jump and branch together, jump wins
      drive(1, 1, 32'h40, 32'h80, 0, 0, 0, 0);
      cyc("t3r");
      check("t3.b1", 64'(if_id_valid), 64'd0);
      idle();
      cyc("t3b2");
      check("t3.b2", 64'(if_id_valid), 64'd0);
      cyc("t3v");
      check("t3.v", 64'(if_id_valid), 64'd1);
      check("t3.i", 64'(if_id_instruction), 64'h11);
      check("t3.p", 64'(if_id_pc_next), 64'h44);

      // 4: freeze drops a jump, continue_en resumes
      saved_addr  = imem_addr;
      saved_instr = if_id_instruction;
      drive(1, 0, 32'h100, 0, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) cyc("t4fz");
      check("t4.pc",  64'(imem_addr), 64'(saved_addr));
      check("t4.ifi", 64'(if_id_instruction), 64'(saved_instr));
      drive(0, 0, 0, 0, 0, 0, 1, 1);
      cyc("t4c1");
      check("t4.adv", 64'(imem_addr), 64'(saved_addr + 8'd1));
      cyc("t4c2");

      // wrap of pc+4 at the top of the address space
      drive(1, 0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
      cyc("wrap0");
      idle();
      cyc("wrap1"); cyc("wrap2");
      check("wrap.p", 64'(if_id_pc_next), 64'd0);
      cyc("wrap3");

      // 5: async reset with a full queue
      drive(0, 0, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 6; i++) cyc("t5f");
      #2 rst_n = 0;
      #1;
      check("t5.v",  64'(if_id_valid), 64'd0);
      check("t5.i",  64'(if_id_instruction), 64'd0);
      check("t5.p",  64'(if_id_pc_next), 64'd0);
      check("t5.ia", 64'(imem_addr), 64'd0);
      model_reset();
      idle();
      @(posedge clk); #1 rst_n = 1;
      cyc("t5r1"); cyc("t5r2");
      check("t5.restart", 64'(if_id_instruction), 64'd1);

`ifdef IF_PERF_CNT_EN
      // 6: 3 fetches then one jump
      idle();
      do_reset();
      cyc("t6a"); cyc("t6b"); cyc("t6c");
      drive(1, 0, 32'h20, 0, 0, 0, 0, 0);
      cyc("t6j");
      check("t6.fetch", 64'(perf_fetch_cnt), 64'd3);
      check("t6.redir", 64'(perf_redirect_cnt), 64'd1);
      bub0 = 32'(perf_bubble_cnt) - 1;
      idle();
      cyc("t6n");
      check("t6.bub2", 64'(perf_bubble_cnt - 32'(bub0)), 64'd2);
`endif

      // randomized mix against the model
      idle();
      for (int n = 0; n < 600; n++) begin
         logic bp;
         bp = ($urandom_range(0, 9) == 0);
         drive($urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
               ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8 : {22'd0, 8'($urandom), 2'b00},
               {22'd0, 8'($urandom), 2'b00},
               $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0,
               bp, bp && ($urandom_range(0, 1) == 1));
         cyc("rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
